// File: rtl/mod_symbol_gen_pkg.sv
// Shared types and constants for the symbol-rate modulation stage.
// Holds the mode encoding, the LFSR seed and width, and the signed sample limits.
package mod_symbol_pkg;

  typedef enum logic [1:0] {
    MODE_ASK  = 2'd0,
    MODE_FSK  = 2'd1,
    MODE_BPSK = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  localparam int                          LFSR_WIDTH = 5;
  localparam logic [LFSR_WIDTH-1:0]       LFSR_SEED  = 5'b00001;
  localparam int                          SAMPLE_W   = 12;
  localparam logic signed [SAMPLE_W-1:0]  SAMPLE_MAX = 12'sd2047;
  localparam logic signed [SAMPLE_W-1:0]  SAMPLE_MIN = -12'sd2048;

  // Two's-complement negation has no +2048, so the most negative input clips to full scale.
  function automatic logic signed [SAMPLE_W-1:0] satNegate(input logic signed [SAMPLE_W-1:0] x);
    return (x == SAMPLE_MIN) ? SAMPLE_MAX : -x;
  endfunction

endpackage

// File: rtl/mod_symbol_gen_if.sv
// Sample/selector bus between the DDS, the selector PIO and the modulation stage.
// master drives selector and carrier; slave is the modulation stage.
interface mod_symbol_gen_if;
  import mod_symbol_pkg::*;

  logic        [3:0]          mod_sel;
  logic signed [SAMPLE_W-1:0] carrier_in;
  logic                       carrier_valid;
  logic        [31:0]         tuning_word;
  logic signed [SAMPLE_W-1:0] mod_out;
  logic                       mod_valid;
  logic                       lfsr_bit;
  logic                       symbol_tick;

  modport master (
    output mod_sel, carrier_in, carrier_valid,
    input  tuning_word, mod_out, mod_valid, lfsr_bit, symbol_tick
  );

  modport slave (
    input  mod_sel, carrier_in, carrier_valid,
    output tuning_word, mod_out, mod_valid, lfsr_bit, symbol_tick
  );

endinterface

// File: rtl/mod_symbol_gen_lfsr5.sv
// 5-bit Fibonacci LFSR (x^5+x^3+1) that advances once per step strobe.
// Period 31 from the seed; the all-zero lock-up state is never reached.
module lfsr5
  import mod_symbol_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  step_i,
  output logic [LFSR_WIDTH-1:0] q_o,
  output logic                  bit_o
);

  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [LFSR_WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign q_o   = lfsr_q;
  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/mod_symbol_gen.sv
// Symbol-rate modulator: ASK/FSK/BPSK/raw-LFSR on the DDS carrier, mode switched only on symbol ticks.
// Define MOD_SYMBOL_GEN_SYNC_EN to pass mod_sel through a 2-flop synchroniser first.
module mod_symbol_gen
  import mod_symbol_pkg::*;
#(
  parameter int          BAUD_DIV = 50_000_000,
  parameter logic [31:0] TW0      = 32'd85899,
  parameter logic [31:0] TW1      = 32'd257698
) (
  input logic             clk,
  input logic             reset_n,
  mod_symbol_gen_if.slave bus
);

  localparam int               CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic        [CNT_W-1:0]      baudCnt_q, baudCnt_d;
  mode_e                        mode_q, mode_d;
  logic signed [SAMPLE_W-1:0]   modOut_q, modOut_d;
  logic                         modValid_q;
  logic        [31:0]           tuningWord_q, tuningWord_d;
  logic        [1:0]            selSrc;
  logic        [LFSR_WIDTH-1:0] lfsrQ;
  logic                         lfsrBit;
  logic                         symbolTick;

  assign symbolTick = (baudCnt_q == CNT_LAST);
  assign baudCnt_d  = symbolTick ? '0 : baudCnt_q + CNT_W'(1);

`ifdef MOD_SYMBOL_GEN_SYNC_EN
  logic [1:0] selSync1_q, selSync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      selSync1_q <= 2'b00;
      selSync2_q <= 2'b00;
    end else begin
      selSync1_q <= bus.mod_sel[1:0];
      selSync2_q <= selSync1_q;
    end
  end

  assign selSrc = selSync2_q;
`else
  assign selSrc = bus.mod_sel[1:0];
`endif

  lfsr5 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step_i  (symbolTick),
    .q_o     (lfsrQ),
    .bit_o   (lfsrBit)
  );

  // Sample and tuning word use the pre-tick bit/mode, so a strobe on the tick cycle finishes the old symbol.
  always_comb begin
    mode_d       = symbolTick ? mode_e'(selSrc) : mode_q;
    tuningWord_d = (mode_q == MODE_FSK && lfsrBit) ? TW1 : TW0;
    modOut_d     = modOut_q;
    if (bus.carrier_valid) begin
      case (mode_q)
        MODE_ASK:  modOut_d = lfsrBit ? bus.carrier_in : '0;
        MODE_FSK:  modOut_d = bus.carrier_in;
        MODE_BPSK: modOut_d = lfsrBit ? bus.carrier_in : satNegate(bus.carrier_in);
        MODE_LFSR: modOut_d = lfsrBit ? SAMPLE_MAX : SAMPLE_MIN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baudCnt_q    <= '0;
      mode_q       <= MODE_ASK;
      modOut_q     <= '0;
      modValid_q   <= 1'b0;
      tuningWord_q <= TW0;
    end else begin
      baudCnt_q    <= baudCnt_d;
      mode_q       <= mode_d;
      modOut_q     <= modOut_d;
      modValid_q   <= bus.carrier_valid;
      tuningWord_q <= tuningWord_d;
    end
  end

  assign bus.symbol_tick = symbolTick;
  assign bus.lfsr_bit    = lfsrQ[0];
  assign bus.mod_out     = modOut_q;
  assign bus.mod_valid   = modValid_q;
  assign bus.tuning_word = tuningWord_q;

endmodule
